// File: rtl/cache_refill.sv
// ---------------------------------------------------------------------------
// cache_refill: single-line cache refill engine.
//
// A miss request in IDLE captures index (addr[8:5]) and tag (addr[63:9]),
// issues one line read to memory, gathers four 64-bit response beats into a
// 256-bit line buffer and writes the line to the data array for one cycle.
//
// Ports
//   clk_i             clock, all state updates on the rising edge
//   rst_n_i           synchronous active-low reset
//   miss_req_i        core requests a refill (honoured only in IDLE)
//   miss_addr_i       miss byte address
//   miss_ack_o        one-cycle pulse when a request is accepted
//   mem_req_valid_o   line read request valid (REQ state)
//   mem_req_ready_i   memory accepts the request
//   mem_req_addr_o    line-aligned request address
//   mem_resp_valid_i  response beat valid (no backpressure)
//   mem_resp_data_i   response beat data
//   data_req_index_o  captured line index
//   data_req_we_o     data-array write enable (WRITE state only)
//   data_write_o      assembled line
//   tag_write_o       captured tag
//   busy_o            high whenever not IDLE
//   err_o             one-cycle timeout pulse
//
// Build option: define CACHE_REFILL_TIMEOUT_EN to add an 8-bit watchdog that
// abandons a refill after 255 cycles without progress in REQ or FILL.
// Without it err_o is tied low and the block waits indefinitely.
// ---------------------------------------------------------------------------
module cache_refill (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         miss_req_i,
    input  logic [63:0]  miss_addr_i,
    output logic         miss_ack_o,
    output logic         mem_req_valid_o,
    input  logic         mem_req_ready_i,
    output logic [63:0]  mem_req_addr_o,
    input  logic         mem_resp_valid_i,
    input  logic [63:0]  mem_resp_data_i,
    output logic [3:0]   data_req_index_o,
    output logic         data_req_we_o,
    output logic [255:0] data_write_o,
    output logic [54:0]  tag_write_o,
    output logic         busy_o,
    output logic         err_o
);

    typedef enum logic [1:0] {StIdle, StReq, StFill, StWrite} state_e;

    state_e         state_q, state_d;
    logic [1:0]     beat_q, beat_d;
    logic [255:0]   line_q, line_d;
    logic [3:0]     index_q, index_d;
    logic [54:0]    tag_q, tag_d;
    logic           timeout;

`ifdef CACHE_REFILL_TIMEOUT_EN
    logic [7:0]     wdog_q, wdog_d;
    logic           progress;

    // Progress means the request handshake or a response beat this cycle.
    assign progress = ((state_q == StReq) && mem_req_ready_i) ||
                      ((state_q == StFill) && mem_resp_valid_i);
    assign timeout  = ((state_q == StReq) || (state_q == StFill)) &&
                      (wdog_q == 8'd255) && !progress;

    always_comb begin
        wdog_d = 8'd0;
        if ((state_q == StReq) || (state_q == StFill)) begin
            if (!progress && !timeout) begin
                wdog_d = wdog_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wdog_q <= 8'd0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            beat_q  <= 2'd0;
            line_q  <= '0;
            index_q <= 4'd0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            index_q <= index_d;
            tag_q   <= tag_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (miss_req_i) state_d = StReq;
            end
            StReq: begin
                if (timeout)              state_d = StIdle;
                else if (mem_req_ready_i) state_d = StFill;
            end
            StFill: begin
                if (timeout)                                  state_d = StIdle;
                else if (mem_resp_valid_i && beat_q == 2'd3)  state_d = StWrite;
            end
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values: capture on accept, fill beats only in FILL.
    always_comb begin
        beat_d  = beat_q;
        line_d  = line_q;
        index_d = index_q;
        tag_d   = tag_q;
        unique case (state_q)
            StIdle: begin
                if (miss_req_i) begin
                    index_d = miss_addr_i[8:5];
                    tag_d   = miss_addr_i[63:9];
                    line_d  = '0;
                    beat_d  = 2'd0;
                end
            end
            StReq: begin
                if (mem_req_ready_i) beat_d = 2'd0;
            end
            StFill: begin
                if (mem_resp_valid_i) begin
                    line_d[{beat_q, 6'd0} +: 64] = mem_resp_data_i;
                    beat_d = beat_q + 2'd1;
                end
            end
            default: ;
        endcase
    end

    // Outputs. Combinational pulses are gated by reset so that every output
    // is low while reset is held.
    always_comb begin
        miss_ack_o       = rst_n_i && (state_q == StIdle) && miss_req_i;
        err_o            = rst_n_i && timeout;
        mem_req_valid_o  = (state_q == StReq);
        mem_req_addr_o   = {tag_q, index_q, 5'd0};
        data_req_we_o    = (state_q == StWrite);
        data_req_index_o = index_q;
        data_write_o     = line_q;
        tag_write_o      = tag_q;
        busy_o           = (state_q != StIdle);
    end

endmodule

// File: tb/tb_cache_refill.sv
module tb_cache_refill;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         miss_req = 1'b0;
    logic [63:0]  miss_addr = '0;
    logic         miss_ack;
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b0;
    logic [63:0]  mem_req_addr;
    logic         mem_resp_valid = 1'b0;
    logic [63:0]  mem_resp_data = '0;
    logic [3:0]   data_req_index;
    logic         data_req_we;
    logic [255:0] data_write;
    logic [54:0]  tag_write;
    logic         busy;
    logic         err;

    cache_refill dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .miss_req_i       (miss_req),
        .miss_addr_i      (miss_addr),
        .miss_ack_o       (miss_ack),
        .mem_req_valid_o  (mem_req_valid),
        .mem_req_ready_i  (mem_req_ready),
        .mem_req_addr_o   (mem_req_addr),
        .mem_resp_valid_i (mem_resp_valid),
        .mem_resp_data_i  (mem_resp_data),
        .data_req_index_o (data_req_index),
        .data_req_we_o    (data_req_we),
        .data_write_o     (data_write),
        .tag_write_o      (tag_write),
        .busy_o           (busy),
        .err_o            (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // pending: a refill is outstanding; hs: memory took the request;
    // beats: data received so far; wdue: the line must be written this cycle.
    bit          m_pending = 0;
    bit          m_hs = 0;
    bit          m_wdue = 0;
    logic [63:0] m_beats[$];
    logic [3:0]  m_idx = '0;
    logic [54:0] m_tag = '0;
    int          m_stall = 0;

    task automatic model_step();
        bit prog;
        if (!rst_n) begin
            m_pending = 0; m_hs = 0; m_wdue = 0; m_beats.delete();
            m_idx = '0; m_tag = '0; m_stall = 0;
        end else if (m_wdue) begin
            m_wdue = 0; m_pending = 0;
        end else if (!m_pending) begin
            if (miss_req) begin
                m_pending = 1; m_hs = 0; m_beats.delete(); m_stall = 0;
                m_idx = miss_addr[8:5];
                m_tag = miss_addr[63:9];
            end
        end else begin
            prog = m_hs ? mem_resp_valid : mem_req_ready;
`ifdef CACHE_REFILL_TIMEOUT_EN
            if (!prog && m_stall == 255) begin
                m_pending = 0; m_stall = 0;
            end else
`endif
            if (!prog) begin
                m_stall++;
            end else begin
                m_stall = 0;
                if (!m_hs) begin
                    m_hs = 1;
                end else begin
                    m_beats.push_back(mem_resp_data);
                    if (m_beats.size() == 4) m_wdue = 1;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    bit           chk_on = 0;
    int           cyc = 0;
    int           ack_cyc = 0;
    int           exp_lat = 6;
    int           write_cnt = 0;
    int           err_cnt = 0;
    logic [3:0]   last_idx = '0;
    logic [255:0] last_line = '0;

    initial forever begin
        logic e_ack, e_err, e_valid;
        @(negedge clk);
        cyc++;
        if (chk_on) begin
            e_ack   = rst_n && !m_pending && miss_req;
            e_valid = m_pending && !m_hs && !m_wdue;
            e_err   = 1'b0;
`ifdef CACHE_REFILL_TIMEOUT_EN
            e_err = rst_n && m_pending && !m_wdue && (m_stall == 255) &&
                    !(m_hs ? mem_resp_valid : mem_req_ready);
`endif
            chk("miss_ack", miss_ack, e_ack);
            chk("busy", busy, m_pending);
            chk("mem_req_valid", mem_req_valid, e_valid);
            chk("data_req_we", data_req_we, m_wdue);
            chk("err", err, e_err);
            chk("index", data_req_index, m_idx);
            chk("tag", tag_write, m_tag);
            if (e_valid) chk("mem_req_addr", mem_req_addr, {m_tag, m_idx, 5'd0});
            if (m_wdue) begin
                chk("data_write", data_write, {m_beats[3], m_beats[2], m_beats[1], m_beats[0]});
                chk("latency", cyc - ack_cyc, exp_lat);
            end
            if (data_req_we) begin
                write_cnt++;
                last_idx  = data_req_index;
                last_line = data_write;
            end
            if (err) err_cnt++;
            if (e_ack) ack_cyc = cyc;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic idle_inputs();
        miss_req = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = rnd64();
    endtask

    // One refill: rdelay cycles before ready, gap idle cycles before each beat.
    // noise adds ignored resp/ready pulses; extra adds ignored miss requests.
    // abort_at < 4 applies reset after that many beats instead of completing.
    task automatic refill(input logic [63:0] addr, input int rdelay, input int gap,
                          input logic [63:0] b0, input logic [63:0] b1,
                          input logic [63:0] b2, input logic [63:0] b3,
                          input bit noise, input bit extra, input int abort_at);
        logic [63:0] bs[4];
        bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
        exp_lat = 6 + rdelay + 4 * gap;
        miss_req = 1; miss_addr = addr;
        mem_req_ready = noise ? 1'($urandom) : 1'b0;
        mem_resp_valid = 0;
        step();
        miss_req = 0; miss_addr = rnd64();
        for (int i = 0; i < rdelay; i++) begin
            mem_req_ready = 0;
            mem_resp_valid = noise ? 1'($urandom) : 1'b0;
            mem_resp_data = rnd64();
            miss_req = extra ? 1'($urandom) : 1'b0;
            step();
        end
        mem_req_ready = 1;
        mem_resp_valid = noise ? 1'($urandom) : 1'b0;
        mem_resp_data = rnd64();
        miss_req = extra;
        step();
        mem_req_ready = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == abort_at) begin
                idle_inputs();
                rst_n = 0;
                step();
                rst_n = 1;
                return;
            end
            for (int g = 0; g < gap; g++) begin
                mem_resp_valid = 0;
                mem_req_ready = noise ? 1'($urandom) : 1'b0;
                miss_req = extra ? 1'($urandom) : 1'b0;
                step();
            end
            mem_resp_valid = 1; mem_resp_data = bs[k];
            miss_req = extra;
            step();
        end
        idle_inputs();
        miss_req = extra;   // lands in the write cycle and must be ignored
        step();
        idle_inputs();
    endtask

    localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;

    initial begin
        int wc;
        logic [255:0] exp_line;
        exp_line = {B4, B3, B2, B1};

        // Reset held with a request present: nothing may respond.
        rst_n = 0; miss_req = 1; miss_addr = 64'hFFFF_FFFF_FFFF_FFE0;
        step();
        chk_on = 1;
        step();
        step();
        chk("rst_ack", miss_ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", mem_req_valid, 0);
        chk("rst_we", data_req_we, 0);
        chk("rst_err", err, 0);
        chk("rst_line", data_write, 0);
        chk("rst_tag", tag_write, 0);
        rst_n = 1; idle_inputs();
        step();

        // Basic refill at minimum latency.
        wc = write_cnt;
        refill(64'h1A0, 0, 0, B1, B2, B3, B4, 0, 0, 4);
        chk("basic_writes", write_cnt - wc, 1);
        chk("basic_idx", last_idx, 4'hD);
        chk("basic_line", last_line, exp_line);

        // Memory stalls: ready after 5 cycles, 3-cycle beat gaps.
        wc = write_cnt;
        refill(64'h1A0, 5, 3, B1, B2, B3, B4, 0, 0, 4);
        step();
        chk("stall_writes", write_cnt - wc, 1);
        chk("stall_line", last_line, exp_line);

        // Blocked second request while filling.
        wc = write_cnt;
        refill(64'h1A0, 1, 2, B1, B2, B3, B4, 0, 1, 4);
        chk("blocked_writes", write_cnt - wc, 1);
        chk("blocked_line", last_line, exp_line);
        step();

        // Reset after two beats, then a clean refill.
        wc = write_cnt;
        refill(64'hABCD_0000_0000_0140, 0, 1, rnd64(), rnd64(), rnd64(), rnd64(), 0, 0, 2);
        chk("abort_busy", busy, 0);
        chk("abort_writes", write_cnt - wc, 0);
        step();
        chk("abort_writes_later", write_cnt - wc, 0);
        refill(64'h1A0, 0, 0, B4, B3, B2, B1, 0, 0, 4);
        chk("clean_line", last_line, {B1, B2, B3, B4});

        // Spurious beats in IDLE, then a normal refill.
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1; mem_resp_data = 64'hDEAD_BEEF_0000_0000 + 64'(i);
            step();
        end
        idle_inputs();
        refill(64'h0000_0000_0000_0060, 2, 0, B2, B4, B1, B3, 0, 0, 4);
        chk("spurious_idx", last_idx, 4'h3);
        chk("spurious_line", last_line, {B3, B1, B4, B2});

        // Randomized refills with ignored noise on all inputs.
        for (int n = 0; n < 40; n++) begin
            refill(rnd64(), $urandom_range(0, 4), $urandom_range(0, 3),
                   rnd64(), rnd64(), rnd64(), rnd64(), 1, 1'($urandom), 4);
            if ($urandom_range(0, 1) == 1) step();
        end

`ifdef CACHE_REFILL_TIMEOUT_EN
        // Ready never arrives: one error pulse, back to IDLE, no write.
        wc = write_cnt;
        err_cnt = 0;
        miss_req = 1; miss_addr = 64'h1A0;
        step();
        idle_inputs();
        for (int i = 0; i < 300; i++) step();
        chk("timeout_err_pulses", err_cnt, 1);
        chk("timeout_writes", write_cnt - wc, 0);
        chk("timeout_busy", busy, 0);
`endif

        step();
        chk("no_err_pulses_default", err_cnt,
`ifdef CACHE_REFILL_TIMEOUT_EN
            1
`else
            0
`endif
        );
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
